// File: rtl/alu_pipelined_stream.sv
// Streaming chunked ripple-carry ALU: one operation per cycle, carry/borrow registered between chunk stages.
// Define ALU_PIPELINED_STREAM_FLAGS_EN to add the registered out_c/out_z/out_v flag outputs.
module alu_pipelined_stream #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
  ,
  output logic             out_c,
  output logic             out_z,
  output logic             out_v
`endif
);

  localparam int AW    = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CC    = (WIDTH + AW - 1) / AW;
  localparam int LASTW = WIDTH - (CC - 1) * AW;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_EQ    = 3'd5,
    OP_LTU   = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  logic             w_adv;
  logic             r_vld [LATENCY];
  op_e              r_op  [LATENCY];
  logic [WIDTH-1:0] r_a   [LATENCY];
  logic [WIDTH-1:0] r_b   [LATENCY];
  logic [WIDTH-1:0] r_res [LATENCY];
  logic             r_cy  [LATENCY];  // carry for ADD, borrow for SUB/LTU
  logic             r_eq  [LATENCY];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
  logic             r_z   [LATENCY];
  logic             r_v   [LATENCY];
`endif

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar s = 0; s < LATENCY; s++) begin : g_st
    logic             w_vld_i;
    op_e              w_op_i;
    logic [WIDTH-1:0] w_a_i;
    logic [WIDTH-1:0] w_b_i;
    logic [WIDTH-1:0] w_res_i;
    logic             w_cy_i;
    logic             w_eq_i;
    logic [WIDTH-1:0] w_res_n;
    logic             w_cy_n;
    logic             w_eq_n;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    logic             w_z_i;
    logic             w_v_i;
    logic             w_z_n;
    logic             w_v_n;
`endif

    if (s == 0) begin : g_head
      assign w_vld_i = in_valid;
      assign w_op_i  = op_e'(in_op);
      assign w_a_i   = in_a;
      assign w_b_i   = in_b;
      assign w_res_i = '0;
      assign w_cy_i  = 1'b0;
      assign w_eq_i  = 1'b1;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
      assign w_z_i   = 1'b1;
      assign w_v_i   = 1'b0;
`endif
    end else begin : g_link
      assign w_vld_i = r_vld[s-1];
      assign w_op_i  = r_op[s-1];
      assign w_a_i   = r_a[s-1];
      assign w_b_i   = r_b[s-1];
      assign w_res_i = r_res[s-1];
      assign w_cy_i  = r_cy[s-1];
      assign w_eq_i  = r_eq[s-1];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
      assign w_z_i   = r_z[s-1];
      assign w_v_i   = r_v[s-1];
`endif
    end

    if (s < CC) begin : g_alu
      localparam int LO = s * AW;
      localparam int SZ = (s == CC - 1) ? LASTW : AW;
      localparam logic [AW:0]   MASK_W = ((AW+1)'(1) << SZ) - (AW+1)'(1);
      localparam logic [AW-1:0] MASK   = MASK_W[AW-1:0];

      logic [AW-1:0] w_ac;
      logic [AW-1:0] w_bc;
      logic [AW-1:0] w_bx;
      logic [AW-1:0] w_rc;
      logic [AW:0]   w_sum;
      logic          w_sub;
      logic          w_cout;

      always_comb begin
        w_sub   = (w_op_i == OP_SUB) || (w_op_i == OP_LTU);
        w_ac    = AW'(w_a_i >> LO) & MASK;
        w_bc    = AW'(w_b_i >> LO) & MASK;
        w_bx    = (w_sub ? ~w_bc : w_bc) & MASK;
        // subtraction runs as a + ~b + !borrow_in, so borrow_out = !carry_out
        w_sum   = {1'b0, w_ac} + {1'b0, w_bx} + (AW+1)'(w_sub ? !w_cy_i : w_cy_i);
        w_cout  = w_sum[SZ];
        case (w_op_i)
          OP_ADD, OP_SUB: w_rc = w_sum[AW-1:0] & MASK;
          OP_AND:         w_rc = w_ac & w_bc;
          OP_OR:          w_rc = w_ac | w_bc;
          OP_XOR:         w_rc = w_ac ^ w_bc;
          OP_PASSA:       w_rc = w_ac;
          default:        w_rc = '0;
        endcase
        w_eq_n  = w_eq_i && (w_ac == w_bc);
        w_cy_n  = (w_op_i == OP_ADD) ? w_cout : (w_sub ? !w_cout : 1'b0);
        w_res_n = w_res_i | (WIDTH'(w_rc) << LO);
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
        w_z_n   = w_z_i && (w_rc == '0);
        w_v_n   = w_v_i;
`endif
        if (s == CC - 1) begin
          if (w_op_i == OP_EQ) begin
            w_res_n = WIDTH'(w_eq_n);
          end else if (w_op_i == OP_LTU) begin
            w_res_n = WIDTH'(w_cy_n);
          end
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
          if (w_op_i == OP_EQ) begin
            w_z_n = !w_eq_n;
          end else if (w_op_i == OP_LTU) begin
            w_z_n = !w_cy_n;
          end
          case (w_op_i)
            OP_ADD:  w_v_n = (w_a_i[WIDTH-1] == w_b_i[WIDTH-1]) && (w_res_n[WIDTH-1] != w_a_i[WIDTH-1]);
            OP_SUB:  w_v_n = (w_a_i[WIDTH-1] != w_b_i[WIDTH-1]) && (w_res_n[WIDTH-1] != w_a_i[WIDTH-1]);
            default: w_v_n = 1'b0;
          endcase
`endif
        end
      end
    end else begin : g_pad
      assign w_res_n = w_res_i;
      assign w_cy_n  = w_cy_i;
      assign w_eq_n  = w_eq_i;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
      assign w_z_n   = w_z_i;
      assign w_v_n   = w_v_i;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld[s] <= 1'b0;
        r_op[s]  <= OP_ADD;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_res[s] <= '0;
        r_cy[s]  <= 1'b0;
        r_eq[s]  <= 1'b0;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
        r_z[s]   <= 1'b0;
        r_v[s]   <= 1'b0;
`endif
      end else if (w_adv) begin
        r_vld[s] <= w_vld_i;
        r_op[s]  <= w_op_i;
        r_a[s]   <= w_a_i;
        r_b[s]   <= w_b_i;
        r_res[s] <= w_res_n;
        r_cy[s]  <= w_cy_n;
        r_eq[s]  <= w_eq_n;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
        r_z[s]   <= w_z_n;
        r_v[s]   <= w_v_n;
`endif
      end
    end
  end

  assign out_valid  = r_vld[LATENCY-1];
  assign out_result = r_res[LATENCY-1];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
  assign out_c = r_cy[LATENCY-1];
  assign out_z = r_z[LATENCY-1];
  assign out_v = r_v[LATENCY-1];
`endif

endmodule

// File: tb/tb_alu_pipelined_stream.sv
// Bench for alu_pipelined_stream: directed scenarios on 8-bit/5-bit instances, random stream on a 37-bit instance.
module tb_alu_pipelined_stream;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-bit, latency 4
  logic       v8 = 0, rdy8 = 1, iready8, ov8;
  logic [2:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, res8;
  // 5-bit, latency 8 and latency 1
  logic       v5a = 0, rdy5a = 1, iready5a, ov5a;
  logic       v5b = 0, rdy5b = 1, iready5b, ov5b;
  logic [2:0] op5 = 0;
  logic [4:0] a5 = 0, b5 = 0, res5a, res5b;
  // 37-bit, latency 5
  logic        v37 = 0, rdy37 = 1, iready37, ov37;
  logic [2:0]  op37 = 0;
  logic [36:0] a37 = 0, b37 = 0, res37;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
  logic c8, z8, vf8, c5a, z5a, vf5a, c5b, z5b, vf5b, c37, z37, vf37;
`endif

  alu_pipelined_stream #(.WIDTH(8), .LATENCY(4)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(iready8), .in_op(op8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(rdy8), .out_result(res8)
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    , .out_c(c8), .out_z(z8), .out_v(vf8)
`endif
  );

  alu_pipelined_stream #(.WIDTH(5), .LATENCY(8)) u_d5a (
    .clk(clk), .rst(rst), .in_valid(v5a), .in_ready(iready5a), .in_op(op5), .in_a(a5), .in_b(b5),
    .out_valid(ov5a), .out_ready(rdy5a), .out_result(res5a)
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    , .out_c(c5a), .out_z(z5a), .out_v(vf5a)
`endif
  );

  alu_pipelined_stream #(.WIDTH(5), .LATENCY(1)) u_d5b (
    .clk(clk), .rst(rst), .in_valid(v5b), .in_ready(iready5b), .in_op(op5), .in_a(a5), .in_b(b5),
    .out_valid(ov5b), .out_ready(rdy5b), .out_result(res5b)
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    , .out_c(c5b), .out_z(z5b), .out_v(vf5b)
`endif
  );

  alu_pipelined_stream #(.WIDTH(37), .LATENCY(5)) u_d37 (
    .clk(clk), .rst(rst), .in_valid(v37), .in_ready(iready37), .in_op(op37), .in_a(a37), .in_b(b37),
    .out_valid(ov37), .out_ready(rdy37), .out_result(res37)
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    , .out_c(c37), .out_z(z37), .out_v(vf37)
`endif
  );

  logic [7:0] q8[$];
  exp_t       q37[$];

  function automatic exp_t model(input int w, input logic [2:0] op, input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t        r;
    logic [64:0] m, a, b, s;
    m = (65'd1 << w) - 65'd1;
    a = {1'b0, a_in} & m;
    b = {1'b0, b_in} & m;
    s = '0;
    r = '0;
    case (op)
      3'd0: begin
        s = a + b;
        r.res = 64'(s & m);
        r.c = s[w];
        r.v = (a[w-1] == b[w-1]) && (r.res[w-1] != a[w-1]);
      end
      3'd1: begin
        s = a - b;
        r.res = 64'(s & m);
        r.c = (a < b);
        r.v = (a[w-1] != b[w-1]) && (r.res[w-1] != a[w-1]);
      end
      3'd2: r.res = 64'(a & b);
      3'd3: r.res = 64'(a | b);
      3'd4: r.res = 64'(a ^ b);
      3'd5: r.res = {63'd0, (a == b)};
      3'd6: begin r.res = {63'd0, (a < b)}; r.c = (a < b); end
      default: r.res = 64'(a);
    endcase
    r.z = (r.res == 64'd0);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    total++;
    if ({ov8, ov5a, ov5b, ov37} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0000", {ov8, ov5a, ov5b, ov37});
    end
    total++;
    if (res8 !== 8'h00 || res5a !== 5'h00 || res5b !== 5'h00 || res37 !== 37'h0) begin
      bad++;
      $display("FAIL reset_result: got %h %h %h %h want zeros", res8, res5a, res5b, res37);
    end
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    total++;
    if ({c8, z8, vf8} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000", {c8, z8, vf8});
    end
`endif
    rst = 1'b0;
    tick();
    total++;
    if ({iready8, iready5a, iready5b, iready37} !== 4'b1111) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1111", {iready8, iready5a, iready5b, iready37});
    end
  endtask

  task automatic test_add_latency;
    int n;
    rdy8 = 1; v8 = 1; op8 = 3'd0; a8 = 8'hFF; b8 = 8'h01;
    tick();
    v8 = 0;
    n = 1;
    while (!ov8 && n < 20) begin tick(); n++; end
    total++;
    if (ov8 !== 1'b1 || n != 4) begin
      bad++;
      $display("FAIL add_latency: got %0d edges (valid=%b) want 4", n, ov8);
    end
    total++;
    if (res8 !== 8'h00) begin
      bad++;
      $display("FAIL add_result: got %h want 00", res8);
    end
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    total++;
    if ({c8, z8, vf8} !== 3'b110) begin
      bad++;
      $display("FAIL add_flags: got cz v=%b want 110", {c8, z8, vf8});
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4];
    logic [7:0] as [4];
    logic [7:0] bs [4];
    logic [7:0] ex [4];
    int idx, got, cyc, first, last;
    ops = '{3'd1, 3'd5, 3'd6, 3'd4};
    as  = '{8'h00, 8'h5A, 8'h10, 8'hF0};
    bs  = '{8'h01, 8'h5A, 8'h20, 8'h3C};
    ex  = '{8'hFF, 8'h01, 8'h01, 8'hCC};
    idx = 0; got = 0; cyc = 0; first = -1; last = -1;
    rdy8 = 1;
    while ((idx < 4 || got < 4) && cyc < 40) begin
      if (idx < 4) begin v8 = 1; op8 = ops[idx]; a8 = as[idx]; b8 = bs[idx]; end
      else v8 = 0;
      #1;
      if (v8 && iready8) begin q8.push_back(ex[idx]); idx++; end
      if (ov8 && rdy8) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected result %h", res8);
        end else begin
          logic [7:0] e;
          e = q8.pop_front();
          if (res8 !== e) begin
            bad++;
            $display("FAIL b2b_result: got %h want %h", res8, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    v8 = 0;
    total++;
    if (got != 4 || last - first != 3) begin
      bad++;
      $display("FAIL b2b_consecutive: got %0d results over %0d cycles want 4 over 3", got, last - first);
    end
  endtask

  task automatic test_backpressure;
    int idx, got, cyc, stalls;
    logic [7:0] ta, tb;
    idx = 0; got = 0; cyc = 0; stalls = 0;
    while ((idx < 6 || got < 6) && cyc < 60) begin
      ta = 8'(idx * 8'h23 + 8'h05);
      tb = 8'(idx * 8'h11 + 8'h80);
      if (idx < 6) begin v8 = 1; op8 = 3'd0; a8 = ta; b8 = tb; end
      else v8 = 0;
      rdy8 = !(cyc >= 5 && cyc <= 7);
      #1;
      total++;
      if (iready8 !== (!ov8 || rdy8)) begin
        bad++;
        $display("FAIL bp_ready: got %b want %b", iready8, (!ov8 || rdy8));
      end
      if (ov8 && !rdy8) stalls++;
      if (v8 && iready8) begin q8.push_back(8'(ta + tb)); idx++; end
      if (ov8 && rdy8) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL bp_extra: unexpected result %h", res8);
        end else begin
          logic [7:0] e;
          e = q8.pop_front();
          if (res8 !== e) begin
            bad++;
            $display("FAIL bp_result: got %h want %h", res8, e);
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    v8 = 0; rdy8 = 1;
    total++;
    if (got != 6 || q8.size() != 0 || stalls != 3) begin
      bad++;
      $display("FAIL bp_count: got %0d results, %0d left, %0d stalls want 6/0/3", got, q8.size(), stalls);
    end
  endtask

  task automatic test_reset_inflight;
    int n, stale;
    rdy8 = 1;
    for (int i = 0; i < 3; i++) begin
      v8 = 1; op8 = 3'd0; a8 = 8'(i + 1); b8 = 8'h10;
      tick();
    end
    v8 = 0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ov8 !== 1'b0 || res8 !== 8'h00) begin
      bad++;
      $display("FAIL rst_inflight: got valid=%b res=%h want 0/00", ov8, res8);
    end
    q8.delete();
    tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov8 !== 1'b0) stale++;
      tick();
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL rst_stale: got %0d valid cycles want 0", stale);
    end
    v8 = 1; op8 = 3'd2; a8 = 8'hC3; b8 = 8'h5A;
    tick();
    v8 = 0;
    n = 1;
    while (!ov8 && n < 20) begin tick(); n++; end
    total++;
    if (ov8 !== 1'b1 || n != 4 || res8 !== 8'h42) begin
      bad++;
      $display("FAIL rst_next_op: got valid=%b edges=%0d res=%h want 1/4/42", ov8, n, res8);
    end
    tick();
  endtask

  task automatic test_padding;
    int n, la, lb;
    logic [4:0] ra, rb;
    rdy5a = 1; rdy5b = 1;
    v5a = 1; v5b = 1; op5 = 3'd0; a5 = 5'h1F; b5 = 5'h01;
    tick();
    v5a = 0; v5b = 0;
    n = 1; la = -1; lb = -1; ra = 5'h1E; rb = 5'h1E;
    while ((la < 0 || lb < 0) && n < 20) begin
      if (ov5a && la < 0) begin la = n; ra = res5a; end
      if (ov5b && lb < 0) begin lb = n; rb = res5b; end
      tick();
      n++;
    end
    total++;
    if (la != 8 || ra !== 5'h00) begin
      bad++;
      $display("FAIL pad_l8: got edges=%0d res=%h want 8/00", la, ra);
    end
    total++;
    if (lb != 1 || rb !== 5'h00) begin
      bad++;
      $display("FAIL pad_l1: got edges=%0d res=%h want 1/00", lb, rb);
    end
  endtask

  task automatic test_random;
    int acc, cyc, emitted;
    exp_t e;
    acc = 0; cyc = 0; emitted = 0;
    while ((acc < 10000 || q37.size() != 0) && cyc < 60000) begin
      v37 = (acc < 10000) && ($urandom_range(0, 9) < 8);
      op37 = 3'($urandom_range(0, 7));
      a37 = 37'({$urandom(), $urandom()});
      b37 = ($urandom_range(0, 5) == 0) ? a37 : 37'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) b37 = a37 + 37'($urandom_range(0, 2)) - 37'd1;
      rdy37 = ($urandom_range(0, 3) != 0);
      #1;
      if (v37 && iready37) begin q37.push_back(model(37, op37, 64'(a37), 64'(b37))); acc++; end
      if (ov37 && rdy37) begin
        total++;
        emitted++;
        if (q37.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra: unexpected result %h", res37);
        end else begin
          e = q37.pop_front();
          if (res37 !== e.res[36:0]) begin
            bad++;
            $display("FAIL rnd_result: got %h want %h", res37, e.res[36:0]);
          end
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
          if ({c37, z37, vf37} !== {e.c, e.z, e.v}) begin
            bad++;
            $display("FAIL rnd_flags: got %b want %b", {c37, z37, vf37}, {e.c, e.z, e.v});
          end
`endif
        end
      end
      tick();
      cyc++;
    end
    v37 = 0; rdy37 = 1;
    total++;
    if (acc != 10000 || emitted != 10000 || q37.size() != 0) begin
      bad++;
      $display("FAIL rnd_count: got accepted=%0d emitted=%0d left=%0d want 10000/10000/0", acc, emitted, q37.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_padding();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
